// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the RAM port and mem_arbiter.
// slave is the arbiter's view; master is the side that supplies requests and RAM status.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: dcache priority with whole-block grants,
// and a starvation counter that forces an icache slot after long dcache traffic.
module mem_arbiter #(
    parameter int unsigned BURST_LEN  = 2,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic         CLK,
    input  logic         nRST,
    mem_arbiter_if.slave bus
);
    localparam int unsigned BW = $clog2(BURST_LEN + 1);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BURST_LEN);
    localparam logic [SW-1:0] SCNT_MAX  = SW'(STARVE_MAX);
    localparam logic [1:0]    RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        DGNT,
        IGNT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    state_t        w_arb;
    logic [BW-1:0] r_bcnt;
    logic [BW-1:0] w_bcnt_nxt;
    logic [BW-1:0] w_bcnt_inc;
    logic [SW-1:0] r_scnt;
    logic [SW-1:0] w_scnt_nxt;
    logic          w_dreq;
    logic          w_access;

    assign w_dreq     = bus.dREN | bus.dWEN;
    assign w_access   = (bus.ramstate == RAM_ACCESS);
    assign w_bcnt_inc = r_bcnt + 1'b1;

    assign bus.iload  = bus.ramload;
    assign bus.dload  = bus.ramload;

    // Starvation check comes first so a saturated icache beats a pending dcache request.
    always_comb begin
        w_arb = IDLE;
        if (bus.iREN && (r_scnt == SCNT_MAX)) begin
            w_arb = IGNT;
        end else if (w_dreq) begin
            w_arb = DGNT;
        end else if (bus.iREN) begin
            w_arb = IGNT;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_bcnt_nxt   = r_bcnt;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;

        unique case (r_state)
            IDLE: begin
                w_next = w_arb;
            end
            DGNT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.dwait    = ~w_access;
                if (!w_dreq) begin
                    w_next     = w_arb;
                    w_bcnt_nxt = '0;
                end else if (w_access) begin
                    if (w_bcnt_inc == BCNT_LAST) begin
                        w_next     = w_arb;
                        w_bcnt_nxt = '0;
                    end else begin
                        w_bcnt_nxt = w_bcnt_inc;
                    end
                end
            end
            IGNT: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                bus.iwait   = ~w_access;
                if (w_access || !bus.iREN) begin
                    w_next = w_arb;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_comb begin
        w_scnt_nxt = r_scnt;
        if (!bus.iREN) begin
            w_scnt_nxt = '0;
        end else if (r_state == IGNT) begin
            if (w_access) begin
                w_scnt_nxt = '0;
            end
        end else if (r_scnt != SCNT_MAX) begin
            w_scnt_nxt = r_scnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_bcnt  <= '0;
            r_scnt  <= '0;
        end else begin
            r_state <= w_next;
            r_bcnt  <= w_bcnt_nxt;
            r_scnt  <= w_scnt_nxt;
        end
    end
endmodule
